// File: rtl/seg7_scan_decoder_pkg.sv
// Shared definitions for the 7-segment scan decoder: glyph patterns ({a..g},
// 1 = lit), FSM state encodings and a one-hot helper.
package seg7_scan_decoder_pkg;

  localparam logic [6:0] SEG_0 = 7'b1111110;
  localparam logic [6:0] SEG_1 = 7'b0110000;
  localparam logic [6:0] SEG_2 = 7'b1101101;
  localparam logic [6:0] SEG_3 = 7'b1111001;
  localparam logic [6:0] SEG_4 = 7'b0110011;
  localparam logic [6:0] SEG_5 = 7'b1011011;
  localparam logic [6:0] SEG_6 = 7'b1011111;
  localparam logic [6:0] SEG_7 = 7'b1110000;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1111011;
  localparam logic [6:0] SEG_A = 7'b1110111;
  localparam logic [6:0] SEG_B = 7'b0011111;
  localparam logic [6:0] SEG_C = 7'b1001110;
  localparam logic [6:0] SEG_D = 7'b0111101;
  localparam logic [6:0] SEG_E = 7'b1001111;
  localparam logic [6:0] SEG_F = 7'b1000111;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  // Select vectors are at most 8 digits wide; narrower ones are zero-extended.
  function automatic logic is_onehot8(input logic [7:0] x);
    return (x != 8'd0) && ((x & (x - 8'd1)) == 8'd0);
  endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational glyph decoder: segment pattern {a..g} to hex value plus a
// valid flag; anything that is not one of the 16 hex glyphs is invalid.
module seg7_pattern_decode
  import seg7_scan_decoder_pkg::*;
(
  input  logic [6:0] seg,
  output logic       valid,
  output logic [3:0] val
);

  always_comb begin
    valid = 1'b1;
    val   = 4'h0;
    case (seg)
      SEG_0:   val = 4'h0;
      SEG_1:   val = 4'h1;
      SEG_2:   val = 4'h2;
      SEG_3:   val = 4'h3;
      SEG_4:   val = 4'h4;
      SEG_5:   val = 4'h5;
      SEG_6:   val = 4'h6;
      SEG_7:   val = 4'h7;
      SEG_8:   val = 4'h8;
      SEG_9:   val = 4'h9;
      SEG_A:   val = 4'hA;
      SEG_B:   val = 4'hB;
      SEG_C:   val = 4'hC;
      SEG_D:   val = 4'hD;
      SEG_E:   val = 4'hE;
      SEG_F:   val = 4'hF;
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Monitors a multiplexed 7-segment bus and recovers the value on each digit
// once its pattern has been stable long enough; reports frames and staleness.
module seg7_scan_decoder
  import seg7_scan_decoder_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int STABLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 1048576,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [7:0]              seg_i,
  input  logic [NUM_DIGITS-1:0]   an_i,
  output logic [4*NUM_DIGITS-1:0] value_o,
  output logic [NUM_DIGITS-1:0]   dp_o,
  output logic [NUM_DIGITS-1:0]   err_o,
  output logic                    frame_valid_o,
  output logic                    stale_o
);

  localparam int CW = $clog2(STABLE_CYCLES);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);
  localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [NUM_DIGITS-1:0] AN_IDLE = (AN_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : '0;
  localparam logic [NUM_DIGITS-1:0] ALL_SEEN = {NUM_DIGITS{1'b1}};

  logic [7:0]            seg_m, seg_s;
  logic [NUM_DIGITS-1:0] an_m, an_s;
  logic [NUM_DIGITS-1:0] sel_m, sel;
  logic [CW-1:0]         cnt;
  logic [TW-1:0]         tcnt;
  logic [NUM_DIGITS-1:0] seen_mask;
  state_t                state;
  logic                  chg, sel_onehot, sel_m_onehot, capture;
  logic                  dec_valid;
  logic [3:0]            dec_val;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_m <= 8'h00;
      seg_s <= 8'h00;
      an_m  <= AN_IDLE;
      an_s  <= AN_IDLE;
    end else begin
      seg_m <= seg_i;
      seg_s <= seg_m;
      an_m  <= an_i;
      an_s  <= an_m;
    end
  end

  assign sel_m = (AN_ACTIVE_LOW != 0) ? ~an_m : an_m;
  assign sel   = (AN_ACTIVE_LOW != 0) ? ~an_s : an_s;
  assign sel_onehot   = is_onehot8(8'(sel));
  assign sel_m_onehot = is_onehot8(8'(sel_m));

  // chg flags that s takes a new value at this edge, so cnt reads 0 in the
  // first cycle of a new pattern and capture lands STABLE_CYCLES samples later.
  assign chg = {an_m, seg_m} != {an_s, seg_s};
  assign capture = (state == ST_SETTLE) && (cnt == CNT_MAX) && sel_onehot;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else if (chg) cnt <= '0;
    else if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
  end

  seg7_pattern_decode u_decode (
    .seg   (seg_s[7:1]),
    .valid (dec_valid),
    .val   (dec_val)
  );

  // FSM plus all registered outputs; capture beats a simultaneous timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      value_o       <= '0;
      dp_o          <= '0;
      err_o         <= '0;
      frame_valid_o <= 1'b0;
      stale_o       <= 1'b0;
      seen_mask     <= '0;
      tcnt          <= '0;
    end else begin
      frame_valid_o <= 1'b0;

      if (chg) begin
        state <= sel_m_onehot ? ST_SETTLE : ST_IDLE;
      end else begin
        case (state)
          ST_IDLE:   if (sel_onehot) state <= ST_SETTLE;
          ST_SETTLE: if (capture) state <= ST_HOLD;
          ST_HOLD:   state <= ST_HOLD;
          default:   state <= ST_IDLE;
        endcase
      end

      if (capture) begin
        for (int k = 0; k < NUM_DIGITS; k++) begin
          if (sel[k]) begin
            value_o[4*k +: 4] <= dec_valid ? dec_val : 4'h0;
            dp_o[k]           <= seg_s[0];
            err_o[k]          <= !dec_valid;
          end
        end
        tcnt <= '0;
        if ((seen_mask | sel) == ALL_SEEN) begin
          seen_mask     <= '0;
          frame_valid_o <= 1'b1;
          stale_o       <= 1'b0;
        end else begin
          seen_mask <= seen_mask | sel;
        end
      end else if (tcnt != T_MAX) begin
        tcnt <= tcnt + 1'b1;
        if (tcnt == T_LAST) begin
          stale_o   <= 1'b1;
          seen_mask <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder: a main instance plus a short-timeout
// instance sharing the same display bus.
module tb_seg7_scan_decoder;

  logic        clk;
  logic        rst_n;
  logic [7:0]  seg_i;
  logic [3:0]  an_i;
  logic [15:0] value_o, value_t;
  logic [3:0]  dp_o, dp_t, err_o, err_t;
  logic        frame_valid_o, frame_t, stale_o, stale_t;

  int errors = 0;
  int checks = 0;
  int frame_cnt = 0;
  int frame_cnt_t = 0;

  seg7_scan_decoder #(
    .NUM_DIGITS(4), .STABLE_CYCLES(16), .TIMEOUT_CYCLES(1024), .AN_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .seg_i(seg_i), .an_i(an_i),
    .value_o(value_o), .dp_o(dp_o), .err_o(err_o),
    .frame_valid_o(frame_valid_o), .stale_o(stale_o)
  );

  seg7_scan_decoder #(
    .NUM_DIGITS(4), .STABLE_CYCLES(16), .TIMEOUT_CYCLES(64), .AN_ACTIVE_LOW(1)
  ) dut_t (
    .clk(clk), .rst_n(rst_n), .seg_i(seg_i), .an_i(an_i),
    .value_o(value_t), .dp_o(dp_t), .err_o(err_t),
    .frame_valid_o(frame_t), .stale_o(stale_t)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_valid_o) frame_cnt++;
    if (frame_t) frame_cnt_t++;
  end

  typedef struct {
    int         digit;
    logic [7:0] seg;
    logic [3:0] val;
    logic       dp;
    logic       err;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic show_digit(input int d, input logic [7:0] s, input int cycles);
    seg_i = s;
    an_i  = ~(4'b0001 << d);
    step(cycles);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_value"}, 32'(value_o), 32'h0);
    check({name, "_dp"}, 32'(dp_o), 32'h0);
    check({name, "_err"}, 32'(err_o), 32'h0);
    check({name, "_frame"}, 32'(frame_valid_o), 32'h0);
    check({name, "_stale"}, 32'(stale_o), 32'h0);
    check({name, "_value_t"}, 32'(value_t), 32'h0);
    check({name, "_stale_t"}, 32'(stale_t), 32'h0);
  endtask

  logic [15:0] exp_value;
  logic [3:0]  exp_dp, exp_err;
  int          frame_base_t;

  initial begin
    vecs[0]  = '{0, 8'b01100000, 4'h1, 1'b0, 1'b0};
    vecs[1]  = '{1, 8'b11011010, 4'h2, 1'b0, 1'b0};
    vecs[2]  = '{2, 8'b11110010, 4'h3, 1'b0, 1'b0};
    vecs[3]  = '{3, 8'b01100110, 4'h4, 1'b0, 1'b0};
    vecs[4]  = '{0, 8'b11111110, 4'h8, 1'b0, 1'b0};
    vecs[5]  = '{1, 8'b00000000, 4'h0, 1'b0, 1'b1};
    vecs[6]  = '{2, 8'b11110110, 4'h9, 1'b0, 1'b0};
    vecs[7]  = '{3, 8'b11111101, 4'h0, 1'b1, 1'b0};
    vecs[8]  = '{0, 8'b11101111, 4'hA, 1'b1, 1'b0};
    vecs[9]  = '{1, 8'b00111110, 4'hB, 1'b0, 1'b0};
    vecs[10] = '{2, 8'b10011101, 4'hC, 1'b1, 1'b0};
    vecs[11] = '{3, 8'b10011110, 4'hE, 1'b0, 1'b0};

    rst_n = 1'b0;
    seg_i = 8'h00;
    an_i  = 4'hF;
    #1;
    check_all_zero("reset");
    step(3);
    rst_n = 1'b1;
    step(2);

    // Capture must land on exactly the 18th rising edge after the pins settle.
    seg_i = 8'b11011010;
    an_i  = 4'b1110;
    step(17);
    check("lat_before_value", 32'(value_o), 32'h0);
    step(1);
    check("lat_edge18_value", 32'(value_o), 32'h0002);
    check("lat_edge18_dp", 32'(dp_o), 32'h0);
    check("lat_edge18_err", 32'(err_o), 32'h0);
    step(22);

    exp_value = 16'h0002;
    exp_dp    = 4'h0;
    exp_err   = 4'h0;
    for (int i = 0; i < 12; i++) begin
      show_digit(vecs[i].digit, vecs[i].seg, 40);
      exp_value[4*vecs[i].digit +: 4] = vecs[i].val;
      exp_dp[vecs[i].digit]  = vecs[i].dp;
      exp_err[vecs[i].digit] = vecs[i].err;
      check($sformatf("vec%0d_value", i), 32'(value_o), 32'(exp_value));
      check($sformatf("vec%0d_dp", i), 32'(dp_o), 32'(exp_dp));
      check($sformatf("vec%0d_err", i), 32'(err_o), 32'(exp_err));
      if (i % 4 == 3)
        check($sformatf("round%0d_frames", i / 4), 32'(frame_cnt), 32'(i / 4 + 1));
    end
    check("scan_final_value", 32'(value_o), 32'hECBA);

    // Pattern changing every 10 cycles never reaches the stability threshold.
    show_digit(1, 8'b11111110, 10);
    show_digit(1, 8'b11110110, 10);
    show_digit(1, 8'b11111100, 10);
    show_digit(1, 8'b10110110, 10);
    show_digit(1, 8'b10111110, 10);
    show_digit(1, 8'b11100000, 10);
    check("glitch_no_capture", 32'(value_o), 32'hECBA);
    show_digit(1, 8'b01111010, 40);
    check("glitch_then_d", 32'(value_o), 32'hECDA);

    seg_i = 8'b11100000;
    an_i  = 4'b1100;
    step(100);
    check("two_sel_value", 32'(value_o), 32'hECDA);
    check("two_sel_dp", 32'(dp_o), 32'h5);
    check("two_sel_err", 32'(err_o), 32'h0);
    show_digit(2, 8'b00000010, 40);
    check("invalid_value", 32'(value_o), 32'hE0DA);
    check("invalid_err", 32'(err_o), 32'h4);
    check("invalid_dp", 32'(dp_o), 32'h1);
    check("frames_before_reset", 32'(frame_cnt), 32'd3);

    // Async reset in the middle of a partial frame.
    show_digit(0, 8'b10110110, 40);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    frame_base_t = frame_cnt_t;
    seg_i = 8'h00;
    an_i  = 4'hF;
    step(2);
    rst_n = 1'b1;
    step(2);
    show_digit(2, 8'b11110010, 40);
    show_digit(3, 8'b01100110, 40);
    check("post_reset_partial_frames", 32'(frame_cnt), 32'd3);
    check("post_reset_partial_frames_t", 32'(frame_cnt_t), 32'(frame_base_t));
    show_digit(0, 8'b01100000, 40);
    show_digit(1, 8'b11011010, 40);
    check("post_reset_frames", 32'(frame_cnt), 32'd4);
    check("post_reset_frames_t", 32'(frame_cnt_t), 32'(frame_base_t + 1));
    check("post_reset_value", 32'(value_o), 32'h4321);

    // Stop scanning after digits 0-1; short-timeout instance goes stale.
    show_digit(0, 8'b11100000, 40);
    show_digit(1, 8'b11110110, 18);
    an_i = 4'hF;
    step(63);
    check("stale_t_before", 32'(stale_t), 32'h0);
    step(1);
    check("stale_t_at_64", 32'(stale_t), 32'h1);
    check("stale_main_quiet", 32'(stale_o), 32'h0);
    check("stale_t_value", 32'(value_t), 32'h4397);
    step(20);
    show_digit(2, 8'b11101110, 40);
    show_digit(3, 8'b00111110, 40);
    check("after_stale_frames", 32'(frame_cnt), 32'd5);
    check("after_stale_frames_t", 32'(frame_cnt_t), 32'(frame_base_t + 1));
    check("after_stale_still_stale", 32'(stale_t), 32'h1);
    show_digit(0, 8'b01100000, 40);
    show_digit(1, 8'b11011010, 40);
    check("rescan_frames_t", 32'(frame_cnt_t), 32'(frame_base_t + 2));
    check("rescan_frames", 32'(frame_cnt), 32'd5);
    check("rescan_stale_t", 32'(stale_t), 32'h0);
    check("rescan_value_t", 32'(value_t), 32'hBA21);
    check("rescan_value", 32'(value_o), 32'hBA21);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
